// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads 16-bit words from the byte memory into a small prefetch FIFO and hands them to decode over valid/ready.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         BUF_DEPTH = 2
) (
  input  logic        fetch_clk,
  input  logic        fetch_rst,
  input  logic        fetch_en,
  input  logic        port_grant,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_addr,
  input  logic [15:0] mem_data_out,
  output logic [7:0]  mem_addr,
  output logic        mem_rd_en,
  output logic        mem_addr_valid,
  output logic        mem_wr_en,
  output logic        word_op,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_data,
  output logic [7:0]  instr_pc,
  output logic [7:0]  fetch_pc,
  output logic        fetch_fault
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic {FETCH, FAULT} state_t;
`else
  typedef enum logic {FETCH} state_t;
`endif

  state_t state, state_nxt;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      buf_data_p1 [BUF_DEPTH];
  logic [7:0]       buf_pc_p1   [BUF_DEPTH];
  logic [15:0]      last_data;
  logic [7:0]       last_pc;
  logic [7:0]       redirect_pc;
  logic             in_fetch;
  logic             issue;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_pc = redirect_addr;
`else
  assign redirect_pc = redirect_addr & 8'hFE;
`endif

  assign in_fetch       = (state == FETCH);
  assign issue          = !fetch_rst && in_fetch && fetch_en && port_grant &&
                          !redirect_valid && (count < DEPTH_C);
  assign instr_valid    = in_fetch && (count != '0);
  assign pop            = instr_valid && instr_ready && !redirect_valid;

  assign mem_addr       = fetch_pc;
  assign mem_rd_en      = issue;
  assign mem_addr_valid = issue;
  assign mem_wr_en      = 1'b0;
  assign word_op        = 1'b1;

  // An empty buffer keeps showing the last head seen by decode.
  assign instr_data = instr_valid ? buf_data_p1[rd_ptr] : last_data;
  assign instr_pc   = instr_valid ? buf_pc_p1[rd_ptr]   : last_pc;

  always_comb begin
    state_nxt   = state;
    fetch_fault = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_fault = (state == FAULT);
    if (redirect_valid) state_nxt = redirect_addr[0] ? FAULT : FETCH;
`else
    state_nxt   = FETCH;
`endif
  end

  always_ff @(posedge fetch_clk) begin
    if (fetch_rst) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_data <= 16'h0000;
      last_pc   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (instr_valid) begin
        last_data <= buf_data_p1[rd_ptr];
        last_pc   <= buf_pc_p1[rd_ptr];
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 8'd2;
          wr_ptr   <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({issue, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Capture stage: memory word and its address land at the FIFO tail.
  always_ff @(posedge fetch_clk) begin
    if (issue) begin
      buf_data_p1[wr_ptr] <= mem_data_out;
      buf_pc_p1[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte memory model, vector table, and hand sequences for the redirect alignment cases.
module tb_instr_fetch_unit;

  logic        fetch_clk = 1'b0;
  logic        fetch_rst;
  logic        fetch_en;
  logic        port_grant;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic [15:0] mem_data_out;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic        mem_addr_valid;
  logic        mem_wr_en;
  logic        word_op;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [7:0]  instr_pc;
  logic [7:0]  fetch_pc;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] addr_p1;

  assign addr_p1      = mem_addr + 8'd1;
  assign mem_data_out = {mem[mem_addr], mem[addr_p1]};

  always #5 fetch_clk = ~fetch_clk;

  instr_fetch_unit #(.RESET_PC(8'h00), .BUF_DEPTH(2)) dut (
    .fetch_clk(fetch_clk), .fetch_rst(fetch_rst), .fetch_en(fetch_en),
    .port_grant(port_grant), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .mem_data_out(mem_data_out),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_addr_valid(mem_addr_valid),
    .mem_wr_en(mem_wr_en), .word_op(word_op), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .fetch_pc(fetch_pc), .fetch_fault(fetch_fault)
  );

  typedef struct {
    logic        rst, en, grant, rv;
    logic [7:0]  raddr;
    logic        rdy;
    logic        exp_rd, exp_vld;
    logic [15:0] exp_data;
    logic [7:0]  exp_ipc, exp_fpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic en, logic g, logic rv, logic [7:0] ra, logic rdy,
                              logic rd, logic vld, logic [15:0] d, logic [7:0] ipc, logic [7:0] fpc);
    vec_t v;
    v.rst = rst; v.en = en; v.grant = g; v.rv = rv; v.raddr = ra; v.rdy = rdy;
    v.exp_rd = rd; v.exp_vld = vld; v.exp_data = d; v.exp_ipc = ipc; v.exp_fpc = fpc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic g, input logic rv,
                       input logic [7:0] ra, input logic rdy);
    fetch_rst = rst; fetch_en = en; port_grant = g;
    redirect_valid = rv; redirect_addr = ra; instr_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge fetch_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'h00; mem[1] = 8'h06; mem[2] = 8'h01; mem[3] = 8'h08; mem[4] = 8'h02;
    mem[5] = 8'h00; mem[6] = 8'hB3; mem[7] = 8'h47; mem[8] = 8'hD8; mem[9] = 8'h8E;

    // rst en g rv raddr rdy | rd vld data ipc fpc
    vecs.push_back(mk(1,0,0,0,8'h00,0, 0,0,16'h0000,8'h00,8'h00));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,0,16'h0000,8'h00,8'h00));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'h0006,8'h00,8'h02));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'h0108,8'h02,8'h04));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'h0200,8'h04,8'h06));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'hB347,8'h06,8'h08));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'hD88E,8'h08,8'h0A));
    vecs.push_back(mk(1,0,0,0,8'h00,0, 0,1,16'h0A0B,8'h0A,8'h0C));
    vecs.push_back(mk(0,1,1,0,8'h00,0, 1,0,16'h0000,8'h00,8'h00));
    vecs.push_back(mk(0,1,1,0,8'h00,0, 1,1,16'h0006,8'h00,8'h02));
    vecs.push_back(mk(0,1,1,0,8'h00,0, 0,1,16'h0006,8'h00,8'h04));
    vecs.push_back(mk(0,1,1,0,8'h00,0, 0,1,16'h0006,8'h00,8'h04));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 0,1,16'h0006,8'h00,8'h04));
    vecs.push_back(mk(0,1,1,0,8'h00,0, 1,1,16'h0108,8'h02,8'h04));
    vecs.push_back(mk(0,1,1,1,8'h06,1, 0,1,16'h0108,8'h02,8'h06));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,0,16'h0108,8'h02,8'h06));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'hB347,8'h06,8'h08));
    vecs.push_back(mk(0,1,1,1,8'hFE,1, 0,1,16'hD88E,8'h08,8'h0A));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,0,16'hD88E,8'h08,8'hFE));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'hFEFF,8'hFE,8'h00));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'h0006,8'h00,8'h02));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,1,16'h0108,8'h02,8'h04));
    vecs.push_back(mk(0,1,0,0,8'h00,1, 0,1,16'h0200,8'h04,8'h06));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,0,16'h0200,8'h04,8'h06));
    vecs.push_back(mk(0,1,0,0,8'h00,1, 0,1,16'hB347,8'h06,8'h08));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 1,0,16'hB347,8'h06,8'h08));
    vecs.push_back(mk(0,1,0,0,8'h00,1, 0,1,16'hD88E,8'h08,8'h0A));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 0,0,16'hD88E,8'h08,8'h0A));
    vecs.push_back(mk(0,1,1,0,8'h00,0, 1,0,16'hD88E,8'h08,8'h0A));

    drive(1, 0, 0, 0, 8'h00, 0);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].grant, vecs[i].rv, vecs[i].raddr, vecs[i].rdy);
      chk("mem_rd_en",      i, 16'(mem_rd_en),      16'(vecs[i].exp_rd));
      chk("mem_addr_valid", i, 16'(mem_addr_valid), 16'(vecs[i].exp_rd));
      chk("instr_valid",    i, 16'(instr_valid),    16'(vecs[i].exp_vld));
      chk("instr_data",     i, instr_data,          vecs[i].exp_data);
      chk("instr_pc",       i, 16'(instr_pc),       16'(vecs[i].exp_ipc));
      chk("fetch_pc",       i, 16'(fetch_pc),       16'(vecs[i].exp_fpc));
      chk("mem_addr",       i, 16'(mem_addr),       16'(vecs[i].exp_fpc));
      chk("fetch_fault",    i, 16'(fetch_fault),    16'h0);
      chk("mem_wr_en",      i, 16'(mem_wr_en),      16'h0);
      chk("word_op",        i, 16'(word_op),        16'h1);
      tick();
    end

    // Odd redirect target while one entry is buffered.
    drive(0, 1, 1, 1, 8'h05, 0);
    chk("odd_redir_rd", 0, 16'(mem_rd_en), 16'h0);
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    drive(0, 1, 1, 0, 8'h00, 1);
    chk("fault_set",     0, 16'(fetch_fault), 16'h1);
    chk("fault_rd",      0, 16'(mem_rd_en),   16'h0);
    chk("fault_vld",     0, 16'(instr_valid), 16'h0);
    chk("fault_pc",      0, 16'(fetch_pc),    16'h05);
    tick();
    drive(0, 1, 1, 0, 8'h00, 1);
    chk("fault_hold",    0, 16'(fetch_fault), 16'h1);
    chk("fault_hold_rd", 0, 16'(mem_rd_en),   16'h0);
    tick();
    drive(0, 1, 1, 1, 8'h04, 1);
    chk("fault_exit_cyc", 0, 16'(fetch_fault), 16'h1);
    tick();
    drive(0, 1, 1, 0, 8'h00, 1);
    chk("fault_clear",   0, 16'(fetch_fault), 16'h0);
    chk("refetch_rd",    0, 16'(mem_rd_en),   16'h1);
    chk("refetch_vld",   0, 16'(instr_valid), 16'h0);
    chk("refetch_pc",    0, 16'(fetch_pc),    16'h04);
    tick();
`else
    drive(0, 1, 1, 0, 8'h00, 1);
    chk("odd_forced_fault", 0, 16'(fetch_fault), 16'h0);
    chk("odd_forced_pc",    0, 16'(fetch_pc),    16'h04);
    chk("odd_forced_rd",    0, 16'(mem_rd_en),   16'h1);
    chk("odd_forced_vld",   0, 16'(instr_valid), 16'h0);
    tick();
`endif
    drive(0, 1, 1, 0, 8'h00, 1);
    chk("target_vld",  0, 16'(instr_valid), 16'h1);
    chk("target_data", 0, instr_data,       16'h0200);
    chk("target_ipc",  0, 16'(instr_pc),    16'h04);
    chk("target_fpc",  0, 16'(fetch_pc),    16'h06);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
